freq_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/edge_sync.sv | 28 ++
 rtl/freq_meter.sv | 105 ++++++++++
 tb/tb_freq_meter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated-window frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DONE
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int GATE_CYCLES_DEFAULT = 50000000;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an external pin with a rising-edge pulse output.
module edge_sync
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts synchronised rising edges over
// GATE_CYCLES clocks, then publishes the count with a one-cycle valid.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal_in,
    input  logic             start,
    input  logic             continuous,
    output logic [WIDTH-1:0] count_out,
    output logic             overflow,
    output logic             valid,
    output logic             busy
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX  = '1;

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [WIDTH-1:0] edge_cnt;
    logic [WIDTH-1:0] edge_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             rise;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(signal_in),
        .rise    (rise)
    );

    // Counter sticks at all-ones; reaching it marks the window as saturated.
    always_comb begin
        edge_nxt = edge_cnt;
        if (rise && edge_cnt != MAX) begin
            edge_nxt = edge_cnt + 1'b1;
        end
        sat_nxt = sat | (edge_nxt == MAX);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            sat       <= 1'b0;
            count_out <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start || continuous) begin
                        state    <= GATE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                GATE: begin
                    edge_cnt <= edge_nxt;
                    sat      <= sat_nxt;
                    gate_cnt <= gate_cnt + 1'b1;
                    if (gate_cnt == LAST) begin
                        state     <= DONE;
                        count_out <= edge_nxt;
                        overflow  <= sat_nxt;
                        valid     <= 1'b1;
                    end
                end
                DONE: begin
                    valid    <= 1'b0;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (continuous) begin
                        state <= GATE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: window-level reference model plus directed scenarios.
module tb_freq_meter;

    localparam int G = 100;
    localparam int S = 2;
    localparam int HN = 8192;

    logic        clock;
    logic        reset;
    logic        signal_in;
    logic        start;
    logic        continuous;
    logic [31:0] count32;
    logic        ovf32;
    logic        valid32;
    logic        busy32;
    logic [3:0]  count4;
    logic        ovf4;
    logic        valid4;
    logic        busy4;

    freq_meter #(
        .WIDTH(32), .GATE_CYCLES(G), .SYNC_STAGES(S)
    ) dut32 (
        .clock(clock), .reset(reset), .signal_in(signal_in),
        .start(start), .continuous(continuous),
        .count_out(count32), .overflow(ovf32),
        .valid(valid32), .busy(busy32)
    );

    freq_meter #(
        .WIDTH(4), .GATE_CYCLES(G), .SYNC_STAGES(S)
    ) dut4 (
        .clock(clock), .reset(reset), .signal_in(signal_in),
        .start(start), .continuous(continuous),
        .count_out(count4), .overflow(ovf4),
        .valid(valid4), .busy(busy4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Signal generator: square wave of period per (high for per/2), or DC.
    int   per = 4;
    int   ph = 0;
    logic dc_level = 1'b0;
    always @(negedge clock) begin
        if (per != 0) begin
            ph = (ph + 1) % per;
            signal_in = (ph < per / 2);
        end else begin
            signal_in = dc_level;
        end
    end

    // Reference model: windows by posedge index; edges from sampled history.
    logic   hist [0:HN-1];
    int     k = 0;
    int     mode = 0;
    int     ws = 0;
    longint e_cnt32 = 0;
    longint e_cnt4 = 0;
    bit     e_ovf32 = 0;
    bit     e_ovf4 = 0;
    bit     e_valid = 0;
    bit     e_busy = 0;

    function automatic int window_edges(input int w);
        int n = 0;
        for (int j = w + 1; j <= w + G; j++) begin
            if (j - S - 1 >= 0 && hist[j-S] && !hist[j-S-1]) n++;
        end
        return n;
    endfunction

    always @(posedge clock) begin
        int n;
        if (k < HN) hist[k] = reset ? signal_in : 1'b0;
        if (!reset) begin
            mode = 0; e_cnt32 = 0; e_cnt4 = 0;
            e_ovf32 = 0; e_ovf4 = 0; e_valid = 0; e_busy = 0;
        end else begin
            case (mode)
                0: if (start || continuous) begin
                    mode = 1; ws = k; e_busy = 1;
                end
                1: if (k == ws + G) begin
                    n = window_edges(ws);
                    e_cnt32 = n;
                    e_ovf32 = (longint'(n) >= 64'hFFFF_FFFF);
                    e_cnt4 = (n > 15) ? 15 : n;
                    e_ovf4 = (n >= 15);
                    e_valid = 1; mode = 2;
                end
                default: begin
                    e_valid = 0;
                    if (continuous) begin
                        mode = 1; ws = k;
                    end else begin
                        mode = 0; e_busy = 0;
                    end
                end
            endcase
        end
        k++;
    end

    int vcount = 0;
    always @(negedge clock) begin
        #1;
        if (valid32) vcount++;
        chk("count32", count32, reset ? e_cnt32 : 0);
        chk("ovf32", ovf32, reset ? e_ovf32 : 0);
        chk("valid32", valid32, reset ? e_valid : 0);
        chk("busy32", busy32, reset ? e_busy : 0);
        chk("count4", count4, reset ? e_cnt4 : 0);
        chk("ovf4", ovf4, reset ? e_ovf4 : 0);
        chk("valid4", valid4, reset ? e_valid : 0);
        chk("busy4", busy4, reset ? e_busy : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = 0;
        for (int n = 1; n <= max; n++) begin
            #1;
            if (valid32) begin
                lat = n;
                break;
            end
            @(negedge clock);
        end
        if (lat == 0) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lat;
    int v0;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        tick(5);
        #1;
        chk("rst_count", count32, 0);
        chk("rst_ovf", ovf32, 0);
        chk("rst_valid", valid32, 0);
        chk("rst_busy", busy32, 0);
        tick(1);
        reset = 1'b1;
        tick(10);
        chk("idle_busy", busy32, 0);

        per = 10;
        tick(20);
        pulse_start();
        wait_valid(300, lat);
        chk("single_latency", lat, 101);
        chk("single_count", count32, 10);
        chk("single_ovf", ovf32, 0);
        tick(3);
        chk("single_busy_end", busy32, 0);

        per = 4;
        tick(8);
        pulse_start();
        wait_valid(300, lat);
        chk("sat_count4", count4, 15);
        chk("sat_ovf4", ovf4, 1);
        chk("sat_count32", count32, 25);
        tick(1);
        per = 10;
        tick(8);
        pulse_start();
        wait_valid(300, lat);
        chk("unsat_count4", count4, 10);
        chk("unsat_ovf4", ovf4, 0);
        tick(3);

        per = 5;
        tick(5);
        continuous = 1'b1;
        tick(1);
        wait_valid(300, lat);
        chk("cont_count_a", (count32 == 19 || count32 == 20), 1);
        tick(1);
        wait_valid(300, lat);
        chk("cont_period", lat, 101);
        chk("cont_count_b", (count32 == 19 || count32 == 20), 1);
        tick(50);
        continuous = 1'b0;
        wait_valid(200, lat);
        chk("cont_last_count", (count32 == 19 || count32 == 20), 1);
        tick(3);
        chk("cont_stop_busy", busy32, 0);
        v0 = vcount;
        tick(200);
        chk("cont_no_more_valid", vcount, v0);

        pulse_start();
        tick(50);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy32, 0);
        chk("midrst_count", count32, 0);
        chk("midrst_count4", count4, 0);
        v0 = vcount;
        tick(2);
        reset = 1'b1;
        tick(200);
        chk("midrst_no_valid", vcount, v0);
        chk("midrst_busy_after", busy32, 0);

        per = 0;
        dc_level = 1'b1;
        tick(10);
        v0 = vcount;
        pulse_start();
        tick(30);
        pulse_start();
        wait_valid(200, lat);
        chk("dc_count", count32, 0);
        tick(150);
        chk("dc_one_valid", vcount - v0, 1);
        chk("dc_busy_end", busy32, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
